// File: rtl/core_run_seq_pkg.sv
// Shared state type and sizing helpers for the core run sequencer.
package core_run_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RELEASE,
        ST_RUN,
        ST_DONE
    } seq_state_t;

    localparam int MAX_CORES = 16;

    // Width of the stagger counter; never narrower than one bit so the
    // unstaggered build still has a legal vector.
    function automatic int stagger_width(input int stagger, input int n_cores);
        int w;
        w = $clog2(stagger * (n_cores - 1) + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/core_run_seq_wdog.sv
// Per-core heartbeat watchdog: counts silent cycles while active and sets a
// sticky flag when the count reaches WDOG_CYCLES.
module core_run_seq_wdog #(
    parameter int CNT_WIDTH   = 16,
    parameter int WDOG_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    input  logic heartbeat,
    output logic timeout
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(WDOG_CYCLES);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q   <= '0;
            timeout <= 1'b0;
        end else if (active && !timeout) begin
            if (heartbeat) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_inc;
                if (cnt_inc == LIMIT) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_run_sequencer.sv
// Reset-and-run controller for up to 16 cores: held reset, staggered release,
// bounded run. Define CORE_RUN_SEQ_WATCHDOG_EN to add per-core heartbeat watchdogs.
//
// state   | meaning
// IDLE    | cores held in reset, waiting for i_start
// RESET   | cores held while the hold counter runs to RST_CYCLES
// RELEASE | cores released one by one, STAGGER cycles apart
// RUN     | all cores released, run counter advancing
// DONE    | run complete or watchdog tripped; waits for i_start
module core_run_sequencer
    import core_run_seq_pkg::*;
#(
    parameter int N_CORES        = 1,
    parameter int CNT_WIDTH      = 16,
    parameter int RST_CYCLES     = 5,
    parameter int STAGGER        = 0,
    parameter int RUN_CYCLES     = 69,
    parameter int AUTO_START     = 1,
    parameter int FREEZE_ON_DONE = 1,
    parameter int WDOG_CYCLES    = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [N_CORES-1:0]   i_heartbeat,
    output logic [N_CORES-1:0]   o_core_rst,
    output logic                 o_running,
    output logic                 o_done,
    output logic [CNT_WIDTH-1:0] o_cycle_count,
    output logic [N_CORES-1:0]   o_timeout
);

    localparam int SW = stagger_width(STAGGER, N_CORES);
    localparam bit STAGGERED = (N_CORES > 1) && (STAGGER > 0);
    localparam logic [CNT_WIDTH-1:0] RST_LIMIT = CNT_WIDTH'(RST_CYCLES);
    localparam logic [CNT_WIDTH-1:0] RUN_LIMIT = CNT_WIDTH'(RUN_CYCLES);
    localparam logic [SW-1:0]        STAG_LAST = SW'(STAGGER * (N_CORES - 1));

    seq_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] hold_q, hold_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [SW-1:0]        stag_q, stag_d;
    logic [N_CORES-1:0]   core_rst_q, core_rst_d;
    logic                 running_q, running_d;
    logic                 done_q, done_d;
    logic                 restart, go_done;
    logic [N_CORES-1:0]   timeout;
    logic                 wdog_trip;

    assign wdog_trip = |timeout;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        count_d    = count_q;
        stag_d     = stag_q;
        core_rst_d = core_rst_q;
        running_d  = running_q;
        done_d     = done_q;
        restart    = 1'b0;
        go_done    = 1'b0;

        unique case (state_q)
            ST_IDLE: restart = i_start;
            ST_RESET: begin
                if (hold_q == RST_LIMIT) begin
                    core_rst_d[0] = 1'b0;
                    stag_d        = '0;
                    if (STAGGERED) begin
                        state_d = ST_RELEASE;
                    end else begin
                        core_rst_d = '0;
                        state_d    = ST_RUN;
                        running_d  = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (wdog_trip) begin
                    go_done = 1'b1;
                end else begin
                    stag_d = stag_q + 1'b1;
                    for (int k = 1; k < N_CORES; k++) begin
                        if (stag_d == SW'(STAGGER * k)) core_rst_d[k] = 1'b0;
                    end
                    if (stag_d == STAG_LAST) begin
                        state_d   = ST_RUN;
                        running_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                count_d = (&count_q) ? count_q : count_q + 1'b1;
                if (wdog_trip || (RUN_CYCLES != 0 && count_d == RUN_LIMIT)) go_done = 1'b1;
            end
            ST_DONE: restart = i_start;
            default: ;
        endcase

        if (go_done) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            running_d = 1'b0;
            if (FREEZE_ON_DONE != 0) core_rst_d = '1;
        end

        // Restart begins as the first counted hold cycle, matching release
        // timing after i_rst.
        if (restart) begin
            state_d    = ST_RESET;
            hold_d     = CNT_WIDTH'(1);
            count_d    = '0;
            stag_d     = '0;
            core_rst_d = '1;
            running_d  = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= (AUTO_START != 0) ? ST_RESET : ST_IDLE;
            hold_q     <= '0;
            count_q    <= '0;
            stag_q     <= '0;
            core_rst_q <= '1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            count_q    <= count_d;
            stag_q     <= stag_d;
            core_rst_q <= core_rst_d;
            running_q  <= running_d;
            done_q     <= done_d;
        end
    end

`ifdef CORE_RUN_SEQ_WATCHDOG_EN
    logic wdog_window;
    assign wdog_window = (state_q == ST_RELEASE) || (state_q == ST_RUN);

    for (genvar k = 0; k < N_CORES; k++) begin : g_wdog
        core_run_seq_wdog #(
            .CNT_WIDTH  (CNT_WIDTH),
            .WDOG_CYCLES(WDOG_CYCLES)
        ) u_wdog (
            .clk      (i_clk),
            .rst      (i_rst),
            .clear    (restart),
            .active   (wdog_window && !core_rst_q[k]),
            .heartbeat(i_heartbeat[k]),
            .timeout  (timeout[k])
        );
    end
`else
    logic unused_wdog_cfg;
    assign unused_wdog_cfg = (^i_heartbeat) ^ (WDOG_CYCLES != 0);
    assign timeout = '0;
`endif

    assign o_core_rst    = core_rst_q;
    assign o_running     = running_q;
    assign o_done        = done_q;
    assign o_cycle_count = count_q;
    assign o_timeout     = timeout;

endmodule

// File: tb/tb_core_run_sequencer.sv
// Bench for core_run_sequencer: two instances (single core defaults, and four
// staggered cores with manual start) checked every cycle against a timeline model.
module tb_core_run_sequencer;

    localparam int A_N = 1, A_RST = 5, A_STAG = 0, A_RUN = 69, A_AUTO = 1, A_FRZ = 1, A_WD = 256;
    localparam int B_N = 4, B_RST = 5, B_STAG = 3, B_RUN = 40, B_AUTO = 0, B_FRZ = 0, B_WD = 16;
    localparam int NEVER = 1 << 30;
`ifdef CORE_RUN_SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    int p_n[2]    = '{A_N, B_N};
    int p_rst[2]  = '{A_RST, B_RST};
    int p_stag[2] = '{A_STAG, B_STAG};
    int p_run[2]  = '{A_RUN, B_RUN};
    int p_auto[2] = '{A_AUTO, B_AUTO};
    int p_frz[2]  = '{A_FRZ, B_FRZ};
    int p_wd[2]   = '{A_WD, B_WD};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_start;
    logic [0:0]  a_hb;
    logic [0:0]  a_core_rst, a_timeout;
    logic        a_running, a_done;
    logic [15:0] a_count;

    logic        b_rst, b_start;
    logic [3:0]  b_hb;
    logic [3:0]  b_core_rst, b_timeout;
    logic        b_running, b_done;
    logic [15:0] b_count;
    logic [3:0]  hb_mask = 4'hF;

    core_run_sequencer #(
        .N_CORES(A_N), .CNT_WIDTH(16), .RST_CYCLES(A_RST), .STAGGER(A_STAG),
        .RUN_CYCLES(A_RUN), .AUTO_START(A_AUTO), .FREEZE_ON_DONE(A_FRZ), .WDOG_CYCLES(A_WD)
    ) dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_start(a_start), .i_heartbeat(a_hb),
        .o_core_rst(a_core_rst), .o_running(a_running), .o_done(a_done),
        .o_cycle_count(a_count), .o_timeout(a_timeout)
    );

    core_run_sequencer #(
        .N_CORES(B_N), .CNT_WIDTH(16), .RST_CYCLES(B_RST), .STAGGER(B_STAG),
        .RUN_CYCLES(B_RUN), .AUTO_START(B_AUTO), .FREEZE_ON_DONE(B_FRZ), .WDOG_CYCLES(B_WD)
    ) dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .i_heartbeat(b_hb),
        .o_core_rst(b_core_rst), .o_running(b_running), .o_done(b_done),
        .o_cycle_count(b_count), .o_timeout(b_timeout)
    );

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: s = edges since the sequence started; everything is a
    // function of s, the edge at which the run ended, and watchdog flags.
    int m_s[2]      = '{0, 0};
    bit m_armed[2]  = '{1'b0, 1'b0};
    int m_done_s[2] = '{NEVER, NEVER};
    int m_quiet[2][4];
    bit m_tout[2][4];

    function automatic int rel_s(input int id, input int k);
        return p_rst[id] + 1 + p_stag[id] * k;
    endfunction

    function automatic int last_s(input int id);
        return rel_s(id, p_n[id] - 1);
    endfunction

    function automatic bit m_done(input int id);
        return m_armed[id] && (m_s[id] >= m_done_s[id]);
    endfunction

    function automatic logic [31:0] exp_core_rst(input int id);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < p_n[id]; k++)
            r[k] = !m_armed[id] || (m_s[id] < rel_s(id, k)) || (m_done(id) && p_frz[id] != 0);
        return r;
    endfunction

    function automatic logic [31:0] exp_running(input int id);
        return 32'(m_armed[id] && m_s[id] >= last_s(id) && !m_done(id));
    endfunction

    function automatic logic [31:0] exp_count(input int id);
        return (m_armed[id] && m_s[id] >= last_s(id)) ? 32'(m_s[id] - last_s(id)) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_timeout(input int id);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < p_n[id]; k++) r[k] = m_tout[id][k];
        return r;
    endfunction

    task automatic clear_wd(input int id);
        for (int k = 0; k < 4; k++) begin
            m_quiet[id][k] = rel_s(id, k);
            m_tout[id][k]  = 1'b0;
        end
    endtask

    task automatic model_step(input int id, input logic rst, input logic start, input logic [3:0] hb);
        bit any_t;
        int s_old;
        if (rst) begin
            m_armed[id]  = (p_auto[id] != 0);
            m_s[id]      = 0;
            m_done_s[id] = NEVER;
            clear_wd(id);
        end else if (!m_armed[id] || m_done(id)) begin
            if (start) begin
                m_armed[id]  = 1'b1;
                m_s[id]      = 1;
                m_done_s[id] = NEVER;
                clear_wd(id);
            end
        end else begin
            any_t = 1'b0;
            for (int k = 0; k < p_n[id]; k++) any_t |= m_tout[id][k];
            s_old = m_s[id];
            m_s[id]++;
            if (WD_EN) begin
                for (int k = 0; k < p_n[id]; k++) begin
                    if (s_old >= rel_s(id, k) && !m_tout[id][k]) begin
                        if (hb[k]) m_quiet[id][k] = m_s[id];
                        else if (m_s[id] - m_quiet[id][k] >= p_wd[id]) m_tout[id][k] = 1'b1;
                    end
                end
            end
            if (any_t) m_done_s[id] = m_s[id];
            if (p_run[id] != 0 && m_s[id] - last_s(id) == p_run[id]) m_done_s[id] = m_s[id];
        end
    endtask

    always @(posedge clk) begin
        model_step(0, a_rst, a_start, {3'b000, a_hb});
        model_step(1, b_rst, b_start, b_hb);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_a_core_rst", 32'(a_core_rst), exp_core_rst(0));
            chk("m_a_running",  32'(a_running),  exp_running(0));
            chk("m_a_done",     32'(a_done),     32'(m_done(0)));
            chk("m_a_count",    32'(a_count),    exp_count(0));
            chk("m_a_timeout",  32'(a_timeout),  exp_timeout(0));
            chk("m_b_core_rst", 32'(b_core_rst), exp_core_rst(1));
            chk("m_b_running",  32'(b_running),  exp_running(1));
            chk("m_b_done",     32'(b_done),     32'(m_done(1)));
            chk("m_b_count",    32'(b_count),    exp_count(1));
            chk("m_b_timeout",  32'(b_timeout),  exp_timeout(1));
        end
    end

    int hb_phase = 0;
    initial begin
        b_hb = 4'b0000;
        forever begin
            @(negedge clk);
            hb_phase++;
            b_hb = (hb_phase % 10 == 0) ? hb_mask : 4'b0000;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0; a_hb = 1'b0;
        step(5);
        chk_en = 1'b1;
        chk("rst_a_core_rst", 32'(a_core_rst), 32'h1);
        chk("rst_a_running",  32'(a_running),  32'h0);
        chk("rst_a_count",    32'(a_count),    32'h0);
        chk("rst_b_core_rst", 32'(b_core_rst), 32'hF);
        chk("rst_b_timeout",  32'(b_timeout),  32'h0);

        a_rst = 1'b0; b_rst = 1'b0;
        step(5);  chk("a_hold_5",     32'(a_core_rst), 32'h1);
        step(1);  chk("a_release",    32'(a_core_rst), 32'h0);
                  chk("a_run_rise",   32'(a_running),  32'h1);
                  chk("a_count_0",    32'(a_count),    32'd0);
        step(1);  chk("a_count_1",    32'(a_count),    32'd1);
        step(43); chk("b_idle_core",  32'(b_core_rst), 32'hF);
                  chk("b_idle_run",   32'(b_running),  32'h0);
        step(24); chk("a_count_68",   32'(a_count),    32'd68);
                  chk("a_not_done",   32'(a_done),     32'h0);
        step(1);  chk("a_done",       32'(a_done),     32'h1);
                  chk("a_count_69",   32'(a_count),    32'd69);
                  chk("a_freeze",     32'(a_core_rst), 32'h1);
        step(3);  chk("a_frozen_cnt", 32'(a_count),    32'd69);

        a_start = 1'b1; step(1); a_start = 1'b0;
        chk("a_restart_done",  32'(a_done),     32'h0);
        chk("a_restart_count", 32'(a_count),    32'd0);
        step(35); chk("a_count_30",  32'(a_count),   32'd30);
        a_start = 1'b1; step(1); a_start = 1'b0;
        chk("a_ign_start_cnt", 32'(a_count),   32'd31);
        chk("a_ign_start_run", 32'(a_running), 32'h1);
        step(38); chk("a_done_2",    32'(a_done),    32'h1);
                  chk("a_count_69b", 32'(a_count),   32'd69);

        a_start = 1'b1; step(1); a_start = 1'b0;
        step(45); chk("a_count_40", 32'(a_count), 32'd40);
        a_rst = 1'b1; a_start = 1'b1; step(1);
        chk("a_abort_core", 32'(a_core_rst), 32'h1);
        chk("a_abort_run",  32'(a_running),  32'h0);
        chk("a_abort_cnt",  32'(a_count),    32'd0);
        a_rst = 1'b0; a_start = 1'b0;
        step(5); chk("a_rehold",    32'(a_core_rst), 32'h1);
        step(1); chk("a_rerelease", 32'(a_core_rst), 32'h0);

        b_start = 1'b1; step(1); b_start = 1'b0;
        step(4);  chk("b_hold",     32'(b_core_rst), 32'hF);
        step(1);  chk("b_rel_0",    32'(b_core_rst), 32'hE);
        step(3);  chk("b_rel_1",    32'(b_core_rst), 32'hC);
        step(3);  chk("b_rel_2",    32'(b_core_rst), 32'h8);
        step(2);  chk("b_pre_run",  32'(b_running),  32'h0);
        step(1);  chk("b_rel_3",    32'(b_core_rst), 32'h0);
                  chk("b_run_rise", 32'(b_running),  32'h1);
        step(40); chk("b_done",     32'(b_done),     32'h1);
                  chk("b_count_40", 32'(b_count),    32'd40);
                  chk("b_no_freeze", 32'(b_core_rst), 32'h0);
                  chk("b_hb_ok",    32'(b_timeout),  32'h0);

        hb_mask = 4'b1101;
        b_start = 1'b1; step(1); b_start = 1'b0;
        chk("b_restart_done", 32'(b_done), 32'h0);
        step(24);
`ifdef CORE_RUN_SEQ_WATCHDOG_EN
        chk("b_tout_flag",  32'(b_timeout), 32'h2);
        chk("b_tout_wait",  32'(b_done),    32'h0);
        step(1);
        chk("b_tout_done",  32'(b_done),    32'h1);
        chk("b_tout_count", 32'(b_count),   32'd11);
`else
        chk("b_no_wdog",    32'(b_timeout), 32'h0);
        step(1);
        chk("b_no_wdog_cnt", 32'(b_count),  32'd11);
`endif
        hb_mask = 4'hF;
        b_start = 1'b1; step(1); b_start = 1'b0;
        chk("b_tout_clear", 32'(b_timeout), 32'h0);
        chk("b_done_clear", 32'(b_done),    32'h0);
        step(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
